sec_tick_timer: RTL and testbench
=================================

Name: sec_tick_timer

Overview:
- Stopwatch stage directly downstream of the 1 s tick generator.
- Consumes the generator's one-cycle enable pulse and keeps an elapsed-time count in MM:SS BCD.
- Start/stop and clear push-buttons, synchronised and edge-detected inside the block.
- BCD digits and status go to the GPIO display and LED logic.

Parameters:
- MAX_MIN, 59, highest minutes value before wrap (1..99).
- SYNC_STAGES, 2, flip-flop depth of each button synchroniser (>=2).

Ports:
- mclk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- tick_en  in  1  one-mclk-cycle enable from the 1 s tick generator
- btn_start_stop  in  1  raw asynchronous button level, active-high
- btn_clear  in  1  raw asynchronous button level, active-high
- sec_ones  out  4  BCD seconds units, 0..9
- sec_tens  out  4  BCD seconds tens, 0..5
- min_ones  out  4  BCD minutes units
- min_tens  out  4  BCD minutes tens
- running  out  1  high while FSM is in RUN
- wrap  out  1  one-cycle pulse on MAX_MIN:59 -> 00:00 rollover

Behaviour:
- Reset: reset is asynchronous, active-low; clock is mclk. While reset=0:
  - all digits = 0, running = 0, wrap = 0
  - FSM = IDLE, synchroniser and edge registers = 0
- Buttons:
  - Each button passes through SYNC_STAGES flops, then a rising-edge detector that produces a one-cycle pulse (ss_p, clr_p).
  - A held button gives exactly one pulse.
  - Latency from raw edge to FSM state change is SYNC_STAGES+1 cycles.
- FSM states and transitions:
  - IDLE: count = 00:00. ss_p -> RUN.
  - RUN: ss_p -> PAUSE.
  - PAUSE: ss_p -> RUN.
  - clr_p from any state -> IDLE and all digits cleared next cycle.
- Counting:
  - Count advances only when the current state is RUN and tick_en=1; the new value is registered, visible the next cycle.
  - BCD carry chain:
    - sec_ones 9->0 carries into sec_tens.
    - sec_tens 5->0 carries into minutes.
    - min_ones 9->0 carries into min_tens.
  - At MAX_MIN:59 a tick gives 00:00 and wrap=1 for that cycle; the FSM stays in RUN.
- Simultaneous events:
  - clr_p beats tick_en and ss_p: the result is IDLE at 00:00, no wrap.
  - RUN + tick_en + ss_p: the tick is counted, then the FSM enters PAUSE.
  - IDLE or PAUSE + tick_en + ss_p: the tick is not counted; RUN starts next cycle.
  - tick_en in IDLE or PAUSE: ignored.
- running is a registered decode of state == RUN.
- Reset mid-count returns everything to reset values immediately, asynchronously.

Optional Feature:
- Macro: SEC_TICK_TIMER_ALARM_EN.
- When defined, the block adds:
  - input alarm_mm [7:0], BCD {tens,ones}
  - input alarm_ss [7:0], BCD {tens,ones}
  - output alarm, 1-bit
- alarm pulses for one cycle on the cycle after a tick-driven increment makes the count equal alarm_mm:alarm_ss.
- alarm never fires from clear or from reset reaching 00:00.
- When not defined, these ports and the compare logic are absent.

Decomposition:
- Shared package sec_timer_pkg:
  - FSM state typedef (IDLE, RUN, PAUSE)
  - BCD_MAX_UNITS=9
  - BCD_MAX_SEC_TENS=5
- One natural sub-module: btn_sync_edge, a parameterised synchroniser plus rising-edge pulse, instantiated once per button.

Test Plan:
- Reset:
  - Stimulus: assert reset=0 mid-count at 03:27.
  - Response: all digits read 0 at once; running=0.
- Start and count:
  - Stimulus: ss pulse, then 61 tick_en pulses spaced 5 cycles apart.
  - Response: running=1 and count reads 01:01.
- Pause and resume:
  - Stimulus: at 00:10 press ss, then 5 ticks, then ss again and 3 ticks.
  - Response: 00:10 holds while paused, then count reaches 00:13.
- Wrap (MAX_MIN=2):
  - Stimulus: run up to 02:59, then one tick.
  - Response: count reads 00:00, wrap=1 for exactly one cycle, running still 1.
- Simultaneous events:
  - Stimulus 1: clr_p and tick_en in the same cycle while in RUN at 00:05.
  - Response: IDLE at 00:00.
  - Stimulus 2: ss_p and tick_en in the same cycle while in RUN at 00:05.
  - Response: 00:06 and PAUSE.
- Button hold:
  - Stimulus: hold btn_start_stop high for 1000 cycles from IDLE.
  - Response: exactly one transition to RUN, state change SYNC_STAGES+1 cycles after the raw edge.

Source files
------------

// File: rtl/sec_timer_pkg.sv
// Shared types and constants for the MM:SS stopwatch stage.
package sec_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } timer_state_t;

  localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser followed by a rising-edge detector.
// A held button yields exactly one single-cycle pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic mclk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Combinational pulse so the FSM reacts SYNC_STAGES+1 edges after the raw edge.
  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/sec_tick_timer.sv
// MM:SS BCD stopwatch driven by the 1 s tick enable, with start/stop and clear buttons.
// Define SEC_TICK_TIMER_ALARM_EN to add the alarm compare ports and logic.
module sec_tick_timer
  import sec_timer_pkg::*;
#(
  parameter int MAX_MIN     = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
`ifdef SEC_TICK_TIMER_ALARM_EN
  output logic       wrap,
  input  logic [7:0] alarm_mm,
  input  logic [7:0] alarm_ss,
  output logic       alarm
`else
  output logic       wrap
`endif
);

  localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

  timer_state_t r_state, w_state_next;
  logic         w_ss_p, w_clr_p, w_count_en, w_clear;
  logic [3:0]   r_sec_ones, r_sec_tens, r_min_ones, r_min_tens;
  logic [3:0]   w_sec_ones, w_sec_tens, w_min_ones, w_min_tens;
  logic         r_running, r_wrap, w_wrap;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .mclk(mclk), .reset(reset), .i_btn(btn_start_stop), .o_pulse(w_ss_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
    .mclk(mclk), .reset(reset), .i_btn(btn_clear), .o_pulse(w_clr_p)
  );

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_running  <= 1'b0;
      r_wrap     <= 1'b0;
      r_sec_ones <= '0;
      r_sec_tens <= '0;
      r_min_ones <= '0;
      r_min_tens <= '0;
    end else begin
      r_state    <= w_state_next;
      r_running  <= (w_state_next == ST_RUN);
      r_wrap     <= w_wrap;
      r_sec_ones <= w_sec_ones;
      r_sec_tens <= w_sec_tens;
      r_min_ones <= w_min_ones;
      r_min_tens <= w_min_tens;
    end
  end

  // Clear outranks everything; a tick in RUN is counted even if ss arrives alongside.
  always_comb begin
    w_state_next = r_state;
    w_count_en   = 1'b0;
    w_clear      = 1'b0;
    if (w_clr_p) begin
      w_state_next = ST_IDLE;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_ss_p) w_state_next = ST_RUN;
        ST_RUN: begin
          w_count_en = tick_en;
          if (w_ss_p) w_state_next = ST_PAUSE;
        end
        ST_PAUSE: if (w_ss_p) w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sec_ones = r_sec_ones;
    w_sec_tens = r_sec_tens;
    w_min_ones = r_min_ones;
    w_min_tens = r_min_tens;
    w_wrap     = 1'b0;
    if (w_clear) begin
      w_sec_ones = '0;
      w_sec_tens = '0;
      w_min_ones = '0;
      w_min_tens = '0;
    end else if (w_count_en) begin
      if (r_sec_ones != BCD_MAX_UNITS) begin
        w_sec_ones = r_sec_ones + 4'd1;
      end else begin
        w_sec_ones = '0;
        if (r_sec_tens != BCD_MAX_SEC_TENS) begin
          w_sec_tens = r_sec_tens + 4'd1;
        end else begin
          w_sec_tens = '0;
          if (r_min_tens == MAX_MIN_TENS && r_min_ones == MAX_MIN_ONES) begin
            w_min_ones = '0;
            w_min_tens = '0;
            w_wrap     = 1'b1;
          end else if (r_min_ones != BCD_MAX_UNITS) begin
            w_min_ones = r_min_ones + 4'd1;
          end else begin
            w_min_ones = '0;
            w_min_tens = r_min_tens + 4'd1;
          end
        end
      end
    end
  end

`ifdef SEC_TICK_TIMER_ALARM_EN
  logic r_alarm;

  // Only tick-driven increments can match, so clear and reset never raise the alarm.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_alarm <= 1'b0;
    end else begin
      r_alarm <= w_count_en &&
                 ({w_min_tens, w_min_ones, w_sec_tens, w_sec_ones} == {alarm_mm, alarm_ss});
    end
  end

  assign alarm = r_alarm;
`endif

  assign sec_ones = r_sec_ones;
  assign sec_tens = r_sec_tens;
  assign min_ones = r_min_ones;
  assign min_tens = r_min_tens;
  assign running  = r_running;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_sec_tick_timer.sv
// Directed plus randomized bench for sec_tick_timer against an elapsed-seconds reference model.
module tb_sec_tick_timer;

  localparam int MAX_MIN = 2;
  localparam int SYNC    = 3;
  localparam int WRAP_AT = (MAX_MIN + 1) * 60;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_en = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, wrap;

  int total = 0;
  int bad = 0;

  // Reference model: elapsed seconds, mode (0 idle, 1 run, 2 pause), raw button history.
  int m_secs = 0;
  int m_mode = 0;
  bit m_wrap = 1'b0;
  bit ss_hist  [0:SYNC+1];
  bit clr_hist [0:SYNC+1];

  sec_tick_timer #(.MAX_MIN(MAX_MIN), .SYNC_STAGES(SYNC)) dut (
    .mclk(mclk), .reset(reset), .tick_en(tick_en),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .wrap(wrap)
  );

  always #10 mclk = ~mclk;

  function automatic logic [31:0] obs_vec();
    return {14'd0, min_tens, min_ones, sec_tens, sec_ones, running, wrap};
  endfunction

  function automatic logic [31:0] exp_vec();
    int m, s;
    m = m_secs / 60;
    s = m_secs % 60;
    return {14'd0, 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), (m_mode == 1), m_wrap};
  endfunction

  function automatic logic [31:0] const_vec(input int mm, input int ss, input bit run, input bit wr);
    return {14'd0, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, wr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_secs = 0;
    m_mode = 0;
    m_wrap = 1'b0;
    for (int i = 0; i <= SYNC + 1; i++) begin
      ss_hist[i]  = 1'b0;
      clr_hist[i] = 1'b0;
    end
  endtask

  // A raw rising level takes SYNC+1 edges to act; the history delays it accordingly.
  task automatic model_edge(input bit t, input bit s, input bit c);
    bit ss_p, clr_p;
    for (int i = SYNC + 1; i > 0; i--) begin
      ss_hist[i]  = ss_hist[i-1];
      clr_hist[i] = clr_hist[i-1];
    end
    ss_hist[0]  = s;
    clr_hist[0] = c;
    ss_p  = ss_hist[SYNC] && !ss_hist[SYNC+1];
    clr_p = clr_hist[SYNC] && !clr_hist[SYNC+1];
    m_wrap = 1'b0;
    if (clr_p) begin
      m_mode = 0;
      m_secs = 0;
    end else begin
      if (m_mode == 1 && t) begin
        m_secs++;
        if (m_secs == WRAP_AT) begin
          m_secs = 0;
          m_wrap = 1'b1;
        end
      end
      if (ss_p) m_mode = (m_mode == 1) ? 2 : 1;
    end
  endtask

  task automatic step(input bit t, input bit s, input bit c);
    tick_en        = t;
    btn_start_stop = s;
    btn_clear      = c;
    @(posedge mclk);
    model_edge(t, s, c);
    #1;
    chk("cycle", obs_vec(), exp_vec());
  endtask

  // Short press; optionally assert tick_en on the very edge the pulse reaches the FSM.
  task automatic press(input bit is_clr, input bit tick_at_pulse);
    for (int i = 0; i <= SYNC; i++)
      step(tick_at_pulse && (i == SYNC), !is_clr && (i < 2), is_clr && (i < 2));
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      for (int j = 0; j < gap; j++) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int latency, rises;
    bit prev_run, b_ss, b_clr;

    model_reset();
    repeat (3) @(posedge mclk);
    #1;
    chk("reset_state", obs_vec(), const_vec(0, 0, 1'b0, 1'b0));
    reset = 1'b1;

    // Start and count to 01:01
    press(1'b0, 1'b0);
    ticks(61, 4);
    chk("start_count", obs_vec(), const_vec(1, 1, 1'b1, 1'b0));

    // Pause and resume
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    ticks(10, 2);
    press(1'b0, 1'b0);
    ticks(5, 2);
    chk("paused_hold", obs_vec(), const_vec(0, 10, 1'b0, 1'b0));
    press(1'b0, 1'b0);
    ticks(3, 2);
    chk("resumed", obs_vec(), const_vec(0, 13, 1'b1, 1'b0));

    // Clear and tick on the same edge in RUN
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    ticks(5, 1);
    press(1'b1, 1'b1);
    chk("clr_beats_tick", obs_vec(), const_vec(0, 0, 1'b0, 1'b0));

    // Start/stop and tick on the same edge in RUN
    press(1'b0, 1'b0);
    ticks(5, 1);
    press(1'b0, 1'b1);
    chk("ss_with_tick_run", obs_vec(), const_vec(0, 6, 1'b0, 1'b0));
    ticks(3, 1);
    chk("pause_ignores_tick", obs_vec(), const_vec(0, 6, 1'b0, 1'b0));

    // Start/stop and tick on the same edge in IDLE
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk("ss_with_tick_idle", obs_vec(), const_vec(0, 0, 1'b1, 1'b0));

    // Wrap from MAX_MIN:59
    ticks(WRAP_AT - 1, 1);
    chk("at_max", obs_vec(), const_vec(MAX_MIN, 59, 1'b1, 1'b0));
    step(1'b1, 1'b0, 1'b0);
    chk("wrap_pulse", obs_vec(), const_vec(0, 0, 1'b1, 1'b1));
    step(1'b0, 1'b0, 1'b0);
    chk("wrap_one_cycle", obs_vec(), const_vec(0, 0, 1'b1, 1'b0));

    // Asynchronous reset mid-count at 02:27
    press(1'b1, 1'b0);
    press(1'b0, 1'b0);
    ticks(147, 1);
    chk("pre_reset", obs_vec(), const_vec(2, 27, 1'b1, 1'b0));
    #4;
    reset = 1'b0;
    #1;
    chk("async_reset", obs_vec(), const_vec(0, 0, 1'b0, 1'b0));
    model_reset();
    repeat (2) @(posedge mclk);
    #1;
    reset = 1'b1;

    // Held start/stop from IDLE: one transition, SYNC+1 edges after the raw edge
    latency  = -1;
    rises    = 0;
    prev_run = running;
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (running && !prev_run) begin
        rises++;
        if (latency < 0) latency = i + 1;
      end
      prev_run = running;
    end
    step(1'b0, 1'b0, 1'b0);
    chk("hold_latency", 32'(latency), 32'(SYNC + 1));
    chk("hold_one_pulse", 32'(rises), 32'd1);

    // Randomized button levels and ticks
    b_ss  = 1'b0;
    b_clr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0)  b_ss  = ~b_ss;
      if ($urandom_range(0, 199) == 0) b_clr = ~b_clr;
      step($urandom_range(0, 2) == 0, b_ss, b_clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
